// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, idle line level and the receiver state type.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous single-bit input.
// Reset loads every flop with a chosen level so no false edge appears when reset is released.
module uart_sync #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {STAGES{RESET_VALUE}};
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, samples mid-bit, and hands each byte to the
// consumer through a valid/ready holding register with frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frameError,
  output logic                 overrun
);

  localparam int PW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [PW-1:0] HALF     = PW'(CLKS_PER_BIT / 2);
  localparam logic [PW-1:0] LAST     = PW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rxs;
  uart_rx_state_t       state, state_next;
  logic [PW-1:0]        phase, phase_next, phase_inc;
  logic [BW-1:0]        bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 sample, commit, frame_err;

  uart_sync #(
    .STAGES     (SYNC_STAGES),
    .RESET_VALUE(IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst_n(nReset),
    .d    (in),
    .q    (rxs)
  );

  assign phase_inc = (phase == LAST) ? '0 : phase + 1'b1;
  assign sample    = (phase == HALF);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
    end
  end

  // The cycle that first sees the start bit is phase 0 of that bit, so every later
  // bit period starts on phase 0 and is sampled at phase HALF.
  always_comb begin
    state_next   = state;
    phase_next   = phase_inc;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    commit       = 1'b0;
    frame_err    = 1'b0;
    case (state)
      IDLE: begin
        phase_next = '0;
        if (!rxs) begin
          phase_next = phase_inc;
          // With a one-clock bit the detecting cycle already is the start bit's sample point.
          if (HALF == '0) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            state_next = START;
          end
        end
      end
      START: begin
        if (sample) begin
          if (!rxs) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            state_next = IDLE;
            phase_next = '0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_next   = {rxs, shift[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (sample) begin
          phase_next = '0;
          if (rxs) begin
            commit     = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        phase_next = '0;
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase
  end

  // A byte accepted on the same edge as a new commit frees the register for the new byte.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      data       <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frameError <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      busy       <= (state_next != IDLE);
      frameError <= frame_err;
      overrun    <= 1'b0;
      if (commit) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level model predicts commit edges, handshake state,
// pulses and busy windows for a CLKS_PER_BIT=4 receiver; a CLKS_PER_BIT=1 receiver covers loopback.
module tb_uart_rx;

  localparam int C    = 4;
  localparam int SYNC = 2;
  localparam int HALF = C / 2;
  localparam int BIG  = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       line = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, busy, ferr, ovr;

  logic       line_f = 1'b1;
  logic       ready_f = 1'b1;
  logic [7:0] data_f;
  logic       valid_f, busy_f, ferr_f, ovr_f;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  bit rand_ready = 1'b0;

  // Frame-level expectations: commit/error edges and busy windows, appended by the driver.
  int         ev_edge[$];
  logic [7:0] ev_byte[$];
  bit         ev_err[$];
  int         ev_rd = 0;
  int         busy_lo[$];
  int         busy_hi[$];
  int         busy_base = 0;

  bit         exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  bit         exp_ferr = 1'b0;
  bit         exp_ovr = 1'b0;

  logic [7:0] rcv[$];
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;

  logic [7:0] fq[$];
  logic [7:0] fexp[$];
  int         fv_cnt = 0;
  int         fv_cyc = 0;
  logic [7:0] fv_data = 8'h00;
  int         f_err_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .in        (line),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frameError(ferr),
    .overrun   (ovr)
  );

  uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(SYNC)) dut_fast (
    .clk       (clk),
    .nReset    (nReset),
    .in        (line_f),
    .data      (data_f),
    .valid     (valid_f),
    .ready     (ready_f),
    .busy      (busy_f),
    .frameError(ferr_f),
    .overrun   (ovr_f)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_busy();
    for (int i = busy_base; i < busy_lo.size(); i++) begin
      if (busy_lo[i] <= cyc && cyc < busy_hi[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model: applies each scheduled frame outcome on its edge, plus the valid/ready rules.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!nReset) begin
      exp_valid <= 1'b0;
      exp_data  <= 8'h00;
      exp_ferr  <= 1'b0;
      exp_ovr   <= 1'b0;
      ev_rd     <= ev_edge.size();
      busy_base <= busy_lo.size();
    end else begin
      exp_ferr <= 1'b0;
      exp_ovr  <= 1'b0;
      if (ev_rd < ev_edge.size() && ev_edge[ev_rd] == cyc + 1) begin
        if (ev_err[ev_rd]) begin
          exp_ferr <= 1'b1;
        end else if (!exp_valid || ready) begin
          exp_valid <= 1'b1;
          exp_data  <= ev_byte[ev_rd];
        end else begin
          exp_ovr <= 1'b1;
        end
        ev_rd <= ev_rd + 1;
      end else if (exp_valid && ready) begin
        exp_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (nReset && chk_on) begin
      checkOutput("valid", valid, exp_valid);
      checkOutput("busy", busy, exp_busy());
      checkOutput("frameError", ferr, exp_ferr);
      checkOutput("overrun", ovr, exp_ovr);
      if (exp_valid) checkOutput("data", data, exp_data);
      if (valid && ready) rcv.push_back(data);
      if (ferr) ferr_cnt <= ferr_cnt + 1;
      if (ovr) ovr_cnt <= ovr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (nReset) begin
      if (valid_f) begin
        fv_cnt  <= fv_cnt + 1;
        fv_data <= data_f;
        fv_cyc  <= cyc;
        fq.push_back(data_f);
      end
      if (ferr_f || ovr_f) f_err_cnt <= f_err_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_bit(input logic v);
    line = v;
    repeat (C) tick();
  endtask

  // Called just after an edge; that edge is the frame's start reference f.
  task automatic applyStimulus(input logic [7:0] b, input bit good);
    int f;
    int done;
    f = cyc;
    done = f + 9 * C + SYNC + HALF + 1;
    ev_edge.push_back(done);
    ev_byte.push_back(b);
    ev_err.push_back(!good);
    busy_lo.push_back(f + SYNC + 1);
    busy_hi.push_back(good ? done : BIG);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good);
  endtask

  task automatic send_fast(input logic [7:0] b);
    line_f = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      line_f = b[i];
      tick();
    end
    line_f = 1'b1;
    tick();
  endtask

  initial begin
    int f;
    int n;
    logic [7:0] b;

    repeat (3) tick();
    checkOutput("reset data", data, 8'h00);
    checkOutput("reset valid", valid, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset frameError", ferr, 1'b0);
    checkOutput("reset overrun", ovr, 1'b0);
    nReset = 1'b1;
    chk_on = 1'b1;
    repeat (3) tick();

    $display("[TB] loopback at one clock per bit");
    f = cyc;
    send_fast(8'hA5);
    repeat (6) tick();
    checkOutput("loop valid cycles", fv_cnt, 1);
    checkOutput("loop data", fv_data, 8'hA5);
    checkOutput("loop latency edge", fv_cyc, f + 12);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      fexp.push_back(b);
      send_fast(b);
    end
    repeat (6) tick();
    checkOutput("loop count", fq.size(), 7);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("loop byte %0d", i), fq[i + 1], fexp[i]);
    checkOutput("loop error pulses", f_err_cnt, 0);

    $display("[TB] back-to-back 00 FF 5A");
    ready = 1'b1;
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h5A, 1'b1);
    repeat (10) tick();
    checkOutput("b2b count", rcv.size(), 3);
    checkOutput("b2b byte0", rcv[0], 8'h00);
    checkOutput("b2b byte1", rcv[1], 8'hFF);
    checkOutput("b2b byte2", rcv[2], 8'h5A);

    $display("[TB] idle glitch");
    n = rcv.size();
    f = cyc;
    busy_lo.push_back(f + SYNC + 1);
    busy_hi.push_back(f + SYNC + 1 + HALF);
    line = 1'b0;
    tick();
    line = 1'b1;
    repeat (12) tick();
    checkOutput("glitch no commit", rcv.size(), n);
    checkOutput("glitch no frameError", ferr_cnt, 0);
    checkOutput("glitch busy", busy, 1'b0);

    $display("[TB] framing error then break");
    applyStimulus(8'h3C, 1'b0);
    repeat (20) tick();
    line = 1'b1;
    busy_hi[busy_hi.size() - 1] = cyc + SYNC + 1;
    repeat (6) tick();
    checkOutput("ferr pulses", ferr_cnt, 1);
    checkOutput("ferr valid", valid, 1'b0);
    checkOutput("ferr no commit", rcv.size(), n);
    applyStimulus(8'h11, 1'b1);
    repeat (8) tick();
    checkOutput("after break count", rcv.size(), n + 1);
    checkOutput("after break byte", rcv[rcv.size() - 1], 8'h11);

    $display("[TB] overrun");
    ready = 1'b0;
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h34, 1'b1);
    repeat (8) tick();
    checkOutput("overrun pulses", ovr_cnt, 1);
    checkOutput("overrun valid held", valid, 1'b1);
    checkOutput("overrun data kept", data, 8'h12);
    ready = 1'b1;
    repeat (2) tick();
    checkOutput("accept drops valid", valid, 1'b0);
    applyStimulus(8'h56, 1'b1);
    repeat (8) tick();
    checkOutput("overrun old byte", rcv[rcv.size() - 2], 8'h12);
    checkOutput("overrun next byte", rcv[rcv.size() - 1], 8'h56);

    $display("[TB] reset mid-frame");
    ready = 1'b0;
    applyStimulus(8'h21, 1'b1);
    repeat (8) tick();
    checkOutput("pre-reset valid", valid, 1'b1);
    f = cyc;
    busy_lo.push_back(f + SYNC + 1);
    busy_hi.push_back(BIG);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    nReset = 1'b0;
    line = 1'b1;
    #1;
    checkOutput("midreset valid", valid, 1'b0);
    checkOutput("midreset busy", busy, 1'b0);
    checkOutput("midreset data", data, 8'h00);
    checkOutput("midreset frameError", ferr, 1'b0);
    checkOutput("midreset overrun", ovr, 1'b0);
    repeat (2) tick();
    nReset = 1'b1;
    ready = 1'b1;
    n = rcv.size();
    tick();
    applyStimulus(8'h88, 1'b1);
    repeat (8) tick();
    checkOutput("post-reset count", rcv.size(), n + 1);
    checkOutput("post-reset byte", rcv[rcv.size() - 1], 8'h88);

    $display("[TB] random frames with random ready");
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 6)) tick();
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    repeat (60) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
